decode_stage: RTL

Registered, parametrised RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides and a 2-entry skid buffer. It sits between fetch and execute and produces decoded control, register indices and a sign-extended immediate one cycle after acceptance. Unlike the earlier combinational decoder, it generalises to XLEN=64 (OP_IMM_32/OP_32, 6-bit shamt), flags illegal encodings per field, and supports flush.

---
 rtl/decode_stage.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decode stage.
//
// Sits between fetch and execute. Each accepted instruction is decoded
// combinationally and written into a 2-entry buffer: a main slot that drives
// the out_* ports and a skid slot. The skid slot catches one entry while
// execute stalls. This keeps in_ready a registered signal (!skid_valid) with
// no combinational path from out_ready.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   flush            drop both slots and any input offered this cycle
//   in_valid/ready   fetch handshake; in_inst (32b) and in_pc (PC_W) payload
//   out_valid/ready  execute handshake
//   out_pc           PC of the presented entry
//   out_rs1/rs2/rd   register indices (rs1 forced to 0 for LUI)
//   out_imm          sign-extended immediate (XLEN), 0 for R-type/illegal
//   out_fmt          one-hot {I,U,R,J,B,S}, 0 when illegal
//   out_alu_op       ADD=0 SUB=1 SLL=2 SLT=3 XOR=4 SRL=5 SRA=6 OR=7 AND=8 NONE=15
//   out_alu_signed   0 only for SLTIU/SLTU
//   out_op1_pc       operand 1 is the PC (AUIPC, JAL, branch target)
//   out_op2_imm      operand 2 is out_imm
//   out_regwrite     entry writes rd
//   out_word         32-bit W-op (XLEN=64 only)
//   out_illegal      entry is an illegal instruction (still passed downstream)
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_fmt,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_signed,
  output logic            out_op1_pc,
  output logic            out_op2_imm,
  output logic            out_regwrite,
  output logic            out_word,
  output logic            out_illegal
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_NONE = 4'd15;

  localparam logic [5:0] FMT_I = 6'b100000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_R = 6'b001000;
  localparam logic [5:0] FMT_J = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000001;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [5:0]      fmt;
    logic [3:0]      alu_op;
    logic            alu_signed;
    logic            op1_pc;
    logic            op2_imm;
    logic            regwrite;
    logic            word;
    logic            illegal;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{alu_op: ALU_NONE, default: '0};

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic logic [3:0] alu_for(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_for = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_for = ALU_SLL;
      3'b010:  alu_for = ALU_SLT;
      3'b011:  alu_for = ALU_SLT;
      3'b100:  alu_for = ALU_XOR;
      3'b101:  alu_for = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_for = ALU_OR;
      default: alu_for = ALU_AND;
    endcase
  endfunction

  // ---------------- field extraction ----------------
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [6:0]        shift_hi;
  logic              funct7_ok;
  logic signed [11:0] raw_i, raw_s;
  logic signed [12:0] raw_b;
  logic signed [31:0] raw_u;
  logic signed [20:0] raw_j;
  logic [5:0]        shamt;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_shw;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  // Bits above the shamt field; at XLEN=64 inst[25] belongs to shamt.
  assign shift_hi  = IS64 ? {in_inst[31:26], 1'b0} : in_inst[31:25];
  assign funct7_ok = (funct7 == 7'h00) ||
                     ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  assign raw_i = in_inst[31:20];
  assign raw_s = {in_inst[31:25], in_inst[11:7]};
  assign raw_b = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign raw_u = {in_inst[31:12], 12'b0};
  assign raw_j = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign shamt = {IS64 & in_inst[25], in_inst[24:20]};

  assign imm_i   = XLEN'(raw_i);
  assign imm_s   = XLEN'(raw_s);
  assign imm_b   = XLEN'(raw_b);
  assign imm_u   = XLEN'(raw_u);
  assign imm_j   = XLEN'(raw_j);
  assign imm_sh  = XLEN'(shamt);
  assign imm_shw = XLEN'(in_inst[24:20]);

  // ---------------- decode ----------------
  entry_t dec;
  logic   illegal;

  // NOTE: every always_comb output gets a default first, so no branch of the
  // case can leave a signal unassigned and infer a latch.
  always_comb begin
    dec            = '0;
    dec.pc         = in_pc;
    dec.rs1        = in_inst[19:15];
    dec.rs2        = in_inst[24:20];
    dec.rd         = in_inst[11:7];
    dec.alu_op     = ALU_ADD;
    dec.alu_signed = 1'b1;
    illegal        = 1'b0;

    case (opcode)
      OPC_LOAD: begin
        dec.fmt = FMT_I; dec.imm = imm_i; dec.op2_imm = 1'b1; dec.regwrite = 1'b1;
        illegal = (funct3 == 3'b111) ||
                  (!IS64 && ((funct3 == 3'b011) || (funct3 == 3'b110)));
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.fmt = FMT_I; dec.imm = imm_i; dec.alu_op = ALU_NONE;
      end
      OPC_OP_IMM: begin
        dec.fmt = FMT_I; dec.op2_imm = 1'b1; dec.regwrite = 1'b1;
        dec.alu_op     = alu_for(funct3, (funct3 == 3'b101) && in_inst[30]);
        dec.alu_signed = (funct3 != 3'b011);
        if (funct3 == 3'b001) begin
          dec.imm = imm_sh;
          illegal = (shift_hi != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_sh;
          illegal = (shift_hi != 7'b0000000) && (shift_hi != 7'b0100000);
        end else begin
          dec.imm = imm_i;
        end
      end
      OPC_OP_IMM_32: begin
        if (IS64) begin
          dec.fmt = FMT_I; dec.op2_imm = 1'b1; dec.regwrite = 1'b1; dec.word = 1'b1;
          dec.alu_op = alu_for(funct3, (funct3 == 3'b101) && in_inst[30]);
          dec.imm    = (funct3 == 3'b000) ? imm_i : imm_shw;
          illegal    = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b101);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP: begin
        dec.fmt = FMT_R; dec.regwrite = 1'b1;
        dec.alu_op     = alu_for(funct3, in_inst[30]);
        dec.alu_signed = (funct3 != 3'b011);
        illegal        = !funct7_ok;
      end
      OPC_OP_32: begin
        if (IS64) begin
          dec.fmt = FMT_R; dec.regwrite = 1'b1; dec.word = 1'b1;
          dec.alu_op = alu_for(funct3, in_inst[30]);
          illegal    = !funct7_ok ||
                       ((funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b101));
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.fmt = FMT_U; dec.imm = imm_u; dec.rs1 = 5'd0;
        dec.op2_imm = 1'b1; dec.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        dec.fmt = FMT_U; dec.imm = imm_u;
        dec.op1_pc = 1'b1; dec.op2_imm = 1'b1; dec.regwrite = 1'b1;
      end
      OPC_JAL: begin
        dec.fmt = FMT_J; dec.imm = imm_j;
        dec.op1_pc = 1'b1; dec.op2_imm = 1'b1; dec.regwrite = 1'b1;
      end
      OPC_JALR: begin
        dec.fmt = FMT_I; dec.imm = imm_i; dec.op2_imm = 1'b1; dec.regwrite = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B; dec.imm = imm_b; dec.op1_pc = 1'b1; dec.op2_imm = 1'b1;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_STORE: begin
        dec.fmt = FMT_S; dec.imm = imm_s; dec.op2_imm = 1'b1;
        illegal = IS64 ? funct3[2] : (funct3 >= 3'b011);
      end
      default: illegal = 1'b1;
    endcase

    // Illegal entries keep PC and raw register fields but carry no control.
    if (illegal) begin
      dec.imm        = '0;
      dec.fmt        = '0;
      dec.alu_op     = ALU_NONE;
      dec.alu_signed = 1'b1;
      dec.op1_pc     = 1'b0;
      dec.op2_imm    = 1'b0;
      dec.regwrite   = 1'b0;
      dec.word       = 1'b0;
    end
    dec.illegal = illegal;
  end

  // ---------------- main/skid buffer ----------------
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept;

  assign accept = in_valid & ~skid_valid_q & ~flush;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      // Main slot frees up: the older skid entry goes first to keep FIFO order.
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      // NOTE: payload slots are reset as well, not only the valid bits,
      // because out_* must read zero (alu_op NONE) while and after reset.
      main_q       <= ENTRY_RESET;
      skid_q       <= ENTRY_RESET;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready       = ~skid_valid_q;
  assign out_valid      = main_valid_q;
  assign out_pc         = main_q.pc;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_rd         = main_q.rd;
  assign out_imm        = main_q.imm;
  assign out_fmt        = main_q.fmt;
  assign out_alu_op     = main_q.alu_op;
  assign out_alu_signed = main_q.alu_signed;
  assign out_op1_pc     = main_q.op1_pc;
  assign out_op2_imm    = main_q.op2_imm;
  assign out_regwrite   = main_q.regwrite;
  assign out_word       = main_q.word;
  assign out_illegal    = main_q.illegal;

endmodule
